// File: rtl/debounce_multi.sv
// N-channel switch debouncer: 2-flop synchroniser, per-channel stability counter,
// registered level output and one-cycle rise/fall pulses.
module debounce_multi #(
    parameter int              N_CH      = 4,
    parameter int              CNT_W     = 4,
    parameter int              CNT_MAX   = 10,
    parameter logic [N_CH-1:0] RESET_VAL = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick,
    input  logic [N_CH-1:0] din,
    output logic [N_CH-1:0] dout,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic [N_CH-1:0]  s1;
    logic [N_CH-1:0]  s2;
    logic [CNT_W-1:0] cnt [N_CH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1   <= RESET_VAL;
            s2   <= RESET_VAL;
            dout <= RESET_VAL;
            rise <= '0;
            fall <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= din;
            s2 <= s1;
            for (int i = 0; i < N_CH; i++) begin
                rise[i] <= 1'b0;
                fall[i] <= 1'b0;
                // any return to the accepted level restarts qualification
                if (s2[i] == dout[i]) begin
                    cnt[i] <= '0;
                end else if (tick) begin
                    if (cnt[i] == CNT_LAST) begin
                        dout[i] <= s2[i];
                        rise[i] <= s2[i];
                        fall[i] <= ~s2[i];
                        cnt[i]  <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule
